// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding load/store front end between a CPU pipeline and a
//   word-wide memory bus. One request is accepted in IDLE, issued in ACCESS
//   (held until ack or timeout), and reported in a single DONE cycle.
//
// Ports
//   iClk, iRst          : rising-edge clock, asynchronous active-high reset
//   iValid / oReady     : request strobe / accept window (high only in IDLE)
//   iLoadTypes[2:0]     : [0] LB, [1] LH, [2] LW
//   iULoadTypes[1:0]    : [0] LBU, [1] LHU
//   iStoreTypes[2:0]    : [0] SB, [1] SH, [2] SW
//   iAddr, iWriteData   : byte address, LSB-aligned store data
//   iRd                 : load destination register
//   oMemReq/We/Addr/WData/Be, iMemAck, iMemRData : memory bus
//   oLoadData, oRd, oWbValid : load write-back (valid in DONE only)
//   oStoreDone          : store completion pulse
//   oMisaligned, oIllegal, oBusErr : one-cycle error pulses
//   oStall              : inverse of oReady
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [2:0]            iLoadTypes,
  input  logic [1:0]            iULoadTypes,
  input  logic [2:0]            iStoreTypes,
  input  logic [ADDR_WIDTH-1:0] iAddr,
  input  logic [31:0]           iWriteData,
  input  logic [4:0]            iRd,
  output logic                  oMemReq,
  output logic                  oMemWe,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic [31:0]           oMemWData,
  output logic [3:0]            oMemBe,
  input  logic                  iMemAck,
  input  logic [31:0]           iMemRData,
  output logic [31:0]           oLoadData,
  output logic [4:0]            oRd,
  output logic                  oWbValid,
  output logic                  oStoreDone,
  output logic                  oMisaligned,
  output logic                  oIllegal,
  output logic                  oBusErr,
  output logic                  oStall
);

  localparam int CW = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic ready_q, ready_d;
  logic req_q, req_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0] be_q, be_d;
  logic [31:0] load_data_q, load_data_d;
  logic [4:0] rd_q, rd_d;
  logic wb_valid_q, wb_valid_d, store_done_q, store_done_d;
  logic misaligned_q, misaligned_d, illegal_q, illegal_d, bus_err_q, bus_err_d;

  // Request attributes kept for the data phase.
  logic [1:0] lat_lo_q, lat_lo_d;
  logic [1:0] lat_size_q, lat_size_d;
  logic lat_uns_q, lat_uns_d;
  logic lat_store_q, lat_store_d;
  logic [4:0] lat_rd_q, lat_rd_d;

  logic [7:0] type_bits;
  logic one_hot, req_half, req_word, req_store, req_uns, misaligned;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign type_bits = {iStoreTypes, iULoadTypes, iLoadTypes};
  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign one_hot   = (type_bits != 8'd0) && ((type_bits & (type_bits - 8'd1)) == 8'd0);
  assign req_half  = iLoadTypes[1] | iULoadTypes[1] | iStoreTypes[1];
  assign req_word  = iLoadTypes[2] | iStoreTypes[2];
  assign req_store = |iStoreTypes;
  assign req_uns   = |iULoadTypes;
  assign misaligned = (req_half & iAddr[0]) | (req_word & (iAddr[1:0] != 2'b00));

  assign byte_sel = iMemRData[{lat_lo_q, 3'b000} +: 8];
  assign half_sel = iMemRData[{lat_lo_q[1], 4'b0000} +: 16];

  always_comb begin
    case (lat_size_q)
      SZ_B:    load_ext = lat_uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    load_ext = lat_uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = iMemRData;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    ready_d      = ready_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    load_data_d  = load_data_q;
    rd_d         = rd_q;
    lat_lo_d     = lat_lo_q;
    lat_size_d   = lat_size_q;
    lat_uns_d    = lat_uns_q;
    lat_store_d  = lat_store_q;
    lat_rd_d     = lat_rd_q;
    wb_valid_d   = 1'b0;
    store_done_d = 1'b0;
    misaligned_d = 1'b0;
    illegal_d    = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (iValid && (type_bits != 8'd0)) begin
          if (!one_hot) begin
            illegal_d = 1'b1;
          end else begin
            lat_lo_d    = iAddr[1:0];
            lat_size_d  = req_word ? SZ_W : (req_half ? SZ_H : SZ_B);
            lat_uns_d   = req_uns;
            lat_store_d = req_store;
            lat_rd_d    = iRd;
            addr_d      = {iAddr[ADDR_WIDTH-1:2], 2'b00};
            we_d        = req_store;
            if (iStoreTypes[0]) begin
              be_d    = 4'b0001 << iAddr[1:0];
              wdata_d = {4{iWriteData[7:0]}};
            end else if (iStoreTypes[1]) begin
              be_d    = 4'b0011 << {iAddr[1], 1'b0};
              wdata_d = {2{iWriteData[15:0]}};
            end else if (iStoreTypes[2]) begin
              be_d    = 4'b1111;
              wdata_d = iWriteData;
            end else begin
              be_d    = 4'b1111;
              wdata_d = 32'd0;
            end
            if (misaligned) begin
              misaligned_d = 1'b1;
            end else begin
              state_d = ACCESS;
              ready_d = 1'b0;
              req_d   = 1'b1;
              wait_d  = '0;
            end
          end
        end
      end
      ACCESS: begin
        // Ack wins over timeout when both land on the same edge.
        if (iMemAck) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (lat_store_q) begin
            store_done_d = 1'b1;
          end else begin
            wb_valid_d  = 1'b1;
            load_data_d = load_ext;
            rd_d        = lat_rd_q;
          end
        end else if (wait_q == CW'(MAX_WAIT - 1)) begin
          state_d   = IDLE;
          ready_d   = 1'b1;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      ready_q      <= 1'b1;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      load_data_q  <= '0;
      rd_q         <= '0;
      lat_lo_q     <= '0;
      lat_size_q   <= '0;
      lat_uns_q    <= 1'b0;
      lat_store_q  <= 1'b0;
      lat_rd_q     <= '0;
      wb_valid_q   <= 1'b0;
      store_done_q <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      ready_q      <= ready_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      load_data_q  <= load_data_d;
      rd_q         <= rd_d;
      lat_lo_q     <= lat_lo_d;
      lat_size_q   <= lat_size_d;
      lat_uns_q    <= lat_uns_d;
      lat_store_q  <= lat_store_d;
      lat_rd_q     <= lat_rd_d;
      wb_valid_q   <= wb_valid_d;
      store_done_q <= store_done_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign oReady      = ready_q;
  assign oStall      = ~ready_q;
  assign oMemReq     = req_q;
  assign oMemWe      = we_q;
  assign oMemAddr    = addr_q;
  assign oMemWData   = wdata_q;
  assign oMemBe      = be_q;
  assign oLoadData   = load_data_q;
  assign oRd         = rd_q;
  assign oWbValid    = wb_valid_q;
  assign oStoreDone  = store_done_q;
  assign oMisaligned = misaligned_q;
  assign oIllegal    = illegal_q;
  assign oBusErr     = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. Result pulses are matched against a
// queue of expected events pushed when each request is driven.
module tb_load_store_unit;

  localparam int AW = 32;
  localparam int MW = 15;

  localparam logic [4:0] K_WB   = 5'b10000;
  localparam logic [4:0] K_ST   = 5'b01000;
  localparam logic [4:0] K_MIS  = 5'b00100;
  localparam logic [4:0] K_ILL  = 5'b00010;
  localparam logic [4:0] K_BERR = 5'b00001;

  typedef struct packed {
    logic [4:0]  kind;
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  logic iClk, iRst, iValid, oReady;
  logic [2:0] iLoadTypes, iStoreTypes;
  logic [1:0] iULoadTypes;
  logic [AW-1:0] iAddr, oMemAddr;
  logic [31:0] iWriteData, oMemWData, iMemRData, oLoadData;
  logic [4:0] iRd, oRd;
  logic oMemReq, oMemWe, iMemAck;
  logic [3:0] oMemBe;
  logic oWbValid, oStoreDone, oMisaligned, oIllegal, oBusErr, oStall;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  load_store_unit #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
    .iLoadTypes(iLoadTypes), .iULoadTypes(iULoadTypes), .iStoreTypes(iStoreTypes),
    .iAddr(iAddr), .iWriteData(iWriteData), .iRd(iRd),
    .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
    .oMemBe(oMemBe), .iMemAck(iMemAck), .iMemRData(iMemRData),
    .oLoadData(oLoadData), .oRd(oRd), .oWbValid(oWbValid), .oStoreDone(oStoreDone),
    .oMisaligned(oMisaligned), .oIllegal(oIllegal), .oBusErr(oBusErr), .oStall(oStall)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and match any result pulse there.
  task automatic tick();
    logic [4:0] pulses;
    exp_t e;
    @(negedge iClk);
    pulses = {oWbValid, oStoreDone, oMisaligned, oIllegal, oBusErr};
    if (pulses != 5'd0) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'(pulses), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", 64'(pulses), 64'(e.kind));
        if (e.kind == K_WB) begin
          chk("load_data", 64'(oLoadData), 64'(e.data));
          chk("load_rd", 64'(oRd), 64'(e.rd));
        end
      end
    end
  endtask

  task automatic push(input logic [4:0] kind, input logic [31:0] data, input logic [4:0] rd);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.rd   = rd;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic [2:0] lt, input logic [1:0] ult, input logic [2:0] st,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    iValid = 1'b1; iLoadTypes = lt; iULoadTypes = ult; iStoreTypes = st;
    iAddr = a; iWriteData = wd; iRd = rd;
    tick();
    iValid = 1'b0; iLoadTypes = '0; iULoadTypes = '0; iStoreTypes = '0;
    iWriteData = $urandom; iAddr = $urandom; iRd = 5'($urandom);
  endtask

  task automatic chk_bus(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd);
    chk("mem_req", 64'(oMemReq), 64'd1);
    chk("mem_addr", 64'(oMemAddr), 64'(a));
    chk("mem_we", 64'(oMemWe), 64'(we));
    chk("mem_be", 64'(oMemBe), 64'(be));
    if (we) chk("mem_wdata", 64'(oMemWData), 64'(wd));
  endtask

  // Called right after acceptance; acks after 'waits' extra ACCESS cycles.
  task automatic do_access(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input int waits, input logic [31:0] rdata);
    for (int i = 0; i < waits; i++) begin
      chk_bus(a, we, be, wd);
      tick();
    end
    chk_bus(a, we, be, wd);
    iMemAck = 1'b1; iMemRData = rdata;
    tick();
    iMemAck = 1'b0; iMemRData = $urandom;
    chk("req_drop_after_ack", 64'(oMemReq), 64'd0);
    chk("done_pulse_on_time", 64'(sb.size()), 64'd0);
    chk("stall_in_done", 64'(oStall), 64'd1);
    tick();
    chk("ready_after_done", 64'(oReady), 64'd1);
  endtask

  initial begin
    iRst = 1'b0; iValid = 1'b0; iLoadTypes = '0; iULoadTypes = '0; iStoreTypes = '0;
    iAddr = '0; iWriteData = '0; iRd = '0; iMemAck = 1'b0; iMemRData = '0;

    // Reset takes effect before any clock edge.
    #2 iRst = 1'b1;
    #1;
    chk("rst_async_ready", 64'(oReady), 64'd1);
    chk("rst_async_req", 64'(oMemReq), 64'd0);
    tick(); tick();
    chk("rst_outputs_zero", {oStall, oMemWe, oMemBe, oWbValid, oStoreDone, oMisaligned, oIllegal, oBusErr}, 64'd0);
    chk("rst_addr_zero", 64'(oMemAddr), 64'd0);
    chk("rst_loaddata_zero", {27'd0, oRd, oLoadData}, 64'd0);
    iRst = 1'b0;
    tick();
    chk("idle_ready", 64'(oReady), 64'd1);

    // LB at 0x1003: top byte 0x80 sign-extended.
    push(K_WB, 32'hFFFF_FF80, 5'd5);
    drive_req(3'b001, 2'b00, 3'b000, 32'h1003, 32'h0, 5'd5);
    chk("stall_in_access", 64'(oStall), 64'd1);
    do_access(32'h1000, 1'b0, 4'b1111, 32'h0, 0, 32'h80FF_1234);
    tick();
    chk("rd_hold", 64'(oRd), 64'd5);
    chk("loaddata_hold", 64'(oLoadData), 64'hFFFF_FF80);

    // LBU at 0x1001 picks byte 1.
    push(K_WB, 32'h0000_0012, 5'd6);
    drive_req(3'b000, 2'b01, 3'b000, 32'h1001, 32'h0, 5'd6);
    do_access(32'h1000, 1'b0, 4'b1111, 32'h0, 2, 32'h80FF_1234);

    // LHU / LH at 0x2002, LHU at 0x2000.
    push(K_WB, 32'h0000_8001, 5'd7);
    drive_req(3'b000, 2'b10, 3'b000, 32'h2002, 32'h0, 5'd7);
    do_access(32'h2000, 1'b0, 4'b1111, 32'h0, 0, 32'h8001_0000);
    push(K_WB, 32'hFFFF_8001, 5'd8);
    drive_req(3'b010, 2'b00, 3'b000, 32'h2002, 32'h0, 5'd8);
    do_access(32'h2000, 1'b0, 4'b1111, 32'h0, 1, 32'h8001_0000);
    push(K_WB, 32'h0000_F00D, 5'd9);
    drive_req(3'b000, 2'b10, 3'b000, 32'h2000, 32'h0, 5'd9);
    do_access(32'h2000, 1'b0, 4'b1111, 32'h0, 0, 32'h8001_F00D);

    // LW passes the word through.
    push(K_WB, 32'hCAFE_F00D, 5'd31);
    drive_req(3'b100, 2'b00, 3'b000, 32'h7000, 32'h0, 5'd31);
    do_access(32'h7000, 1'b0, 4'b1111, 32'h0, 3, 32'hCAFE_F00D);

    // Stores.
    push(K_ST, 32'h0, 5'd0);
    drive_req(3'b000, 2'b00, 3'b001, 32'h3001, 32'h0000_00AB, 5'd0);
    do_access(32'h3000, 1'b1, 4'b0010, 32'hABAB_ABAB, 0, 32'h0);
    push(K_ST, 32'h0, 5'd0);
    drive_req(3'b000, 2'b00, 3'b010, 32'h5002, 32'h1234_CDEF, 5'd0);
    do_access(32'h5000, 1'b1, 4'b1100, 32'hCDEF_CDEF, 1, 32'h0);
    push(K_ST, 32'h0, 5'd0);
    drive_req(3'b000, 2'b00, 3'b100, 32'h6000, 32'hDEAD_BEEF, 5'd0);
    do_access(32'h6000, 1'b1, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0);

    // A request during DONE is not accepted.
    push(K_WB, 32'h0000_0034, 5'd3);
    drive_req(3'b001, 2'b00, 3'b000, 32'h1000, 32'h0, 5'd3);
    iMemAck = 1'b1; iMemRData = 32'h80FF_1234;
    tick();
    iMemAck = 1'b0;
    drive_req(3'b100, 2'b00, 3'b000, 32'h8000, 32'h0, 5'd4);
    chk("done_no_accept_req", 64'(oMemReq), 64'd0);
    chk("done_no_accept_ready", 64'(oReady), 64'd1);

    // Misaligned and illegal requests never reach the bus.
    push(K_MIS, 32'h0, 5'd0);
    drive_req(3'b100, 2'b00, 3'b000, 32'h4002, 32'h0, 5'd1);
    chk("mis_no_req", 64'(oMemReq), 64'd0);
    chk("mis_ready", 64'(oReady), 64'd1);
    push(K_MIS, 32'h0, 5'd0);
    drive_req(3'b000, 2'b00, 3'b010, 32'h4001, 32'h0, 5'd1);
    push(K_ILL, 32'h0, 5'd0);
    drive_req(3'b001, 2'b00, 3'b001, 32'h4000, 32'h0, 5'd1);
    chk("ill_no_req", 64'(oMemReq), 64'd0);
    tick();
    chk("ill_still_idle", 64'(oReady), 64'd1);

    // No type bits and stray ack are both ignored.
    drive_req(3'b000, 2'b00, 3'b000, 32'h4000, 32'h0, 5'd1);
    iMemAck = 1'b1;
    tick();
    iMemAck = 1'b0;
    tick();
    chk("ignored_no_req", 64'(oMemReq), 64'd0);
    chk("ignored_ready", 64'(oReady), 64'd1);

    // Ack withheld: exactly MW request cycles, then bus error.
    push(K_BERR, 32'h0, 5'd0);
    drive_req(3'b100, 2'b00, 3'b000, 32'h9000, 32'h0, 5'd2);
    for (int i = 0; i < MW; i++) begin
      chk("berr_req_held", 64'(oMemReq), 64'd1);
      tick();
    end
    chk("berr_req_drop", 64'(oMemReq), 64'd0);
    chk("berr_ready", 64'(oReady), 64'd1);
    chk("berr_pulse_on_time", 64'(sb.size()), 64'd0);

    // Ack in the last allowed cycle completes normally.
    push(K_WB, 32'h1357_9BDF, 5'd12);
    drive_req(3'b100, 2'b00, 3'b000, 32'hA000, 32'h0, 5'd12);
    do_access(32'hA000, 1'b0, 4'b1111, 32'h0, MW - 1, 32'h1357_9BDF);

    // Reset mid-ACCESS drops the request at once, with no pulses.
    drive_req(3'b100, 2'b00, 3'b000, 32'hB000, 32'h0, 5'd13);
    tick(); tick();
    #2 iRst = 1'b1;
    #1;
    chk("rst_mid_req_async", 64'(oMemReq), 64'd0);
    chk("rst_mid_ready", 64'(oReady), 64'd1);
    tick();
    iRst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rst_mid_idle", 64'(oReady), 64'd1);
    push(K_WB, 32'h2468_ACE0, 5'd14);
    drive_req(3'b100, 2'b00, 3'b000, 32'hC000, 32'h0, 5'd14);
    do_access(32'hC000, 1'b0, 4'b1111, 32'h0, 0, 32'h2468_ACE0);

    // Bounded drain of any outstanding expectations.
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: byte-address width of iAddr/oMemAddr.
REQ-002 SHALL have parameter MAX_WAIT, default 15: ACCESS cycles without iMemAck before bus error.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: iClk in 1 (rising-edge clock); iRst in 1 (async active-high reset).
REQ-004 SHALL have ports: iValid in 1 (request strobe); oReady out 1 (high only in IDLE).
REQ-005 SHALL have ports: iLoadTypes in 3 (bit1 LB, bit2 LH, bit3 LW); iULoadTypes in 2 (bit1 LBU, bit2 LHU); iStoreTypes in 3 (bit1 SB, bit2 SH, bit3 SW).
REQ-006 SHALL have ports: iAddr in ADDR_WIDTH (byte address); iWriteData in 32 (store data, LSB-aligned); iRd in 5 (load destination).
REQ-007 SHALL have ports: oMemReq out 1; oMemWe out 1; oMemAddr out ADDR_WIDTH (word-aligned, [1:0]=0); oMemWData out 32; oMemBe out 4; iMemAck in 1; iMemRData in 32.
REQ-008 SHALL have ports: oLoadData out 32; oRd out 5; oWbValid out 1 (load result pulse); oStoreDone out 1 (store pulse).
REQ-009 SHALL have ports: oMisaligned out 1; oIllegal out 1; oBusErr out 1 (all one-cycle pulses); oStall out 1 (= not oReady).

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, DONE; all outputs are registered.
REQ-011 In IDLE, iValid with all 8 type bits zero SHALL be ignored.
REQ-012 In IDLE, iValid with more than one type bit set SHALL pulse oIllegal next cycle, with no memory access, and remain in IDLE.
REQ-013 In IDLE, iValid with exactly one type bit set SHALL latch the address, data, rd and type; a misaligned access (halfword with iAddr[0]=1, word with iAddr[1:0]!=0) SHALL pulse oMisaligned next cycle and remain in IDLE.
REQ-014 In IDLE, an aligned access SHALL move to ACCESS; oMemReq SHALL be high from the next cycle and held, with oMemAddr/oMemWe/oMemBe/oMemWData stable, until iMemAck is sampled high.
REQ-015 Byte enables SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b1111.
REQ-016 Store data SHALL be: SB {4{wd[7:0]}}; SH {2{wd[15:0]}}; SW wd.
REQ-017 In ACCESS, iMemAck sampled high SHALL deassert oMemReq next cycle and enter DONE; a load SHALL capture iMemRData on that edge.
REQ-018 Load extraction SHALL select byte = rdata[8*addr[1:0] +: 8] and half = rdata[16*addr[1] +: 16]; LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
REQ-019 DONE SHALL last exactly one cycle: for loads, oWbValid=1 with valid oLoadData and oRd; for stores, oStoreDone=1. The FSM then returns to IDLE.
REQ-020 A new request SHALL NOT be accepted in DONE; back-to-back throughput is one access per 3 cycles at zero memory wait.
REQ-021 A wait counter (4 bits minimum) SHALL clear on ACCESS entry and increment each ACCESS cycle without ack; reaching MAX_WAIT SHALL drop oMemReq, pulse oBusErr, and return to IDLE.
REQ-022 Ack in the same cycle the counter reaches MAX_WAIT SHALL count as success, with no bus error.
REQ-023 iMemAck outside ACCESS SHALL be ignored.
REQ-024 oLoadData/oRd SHALL hold their last value outside DONE.

Reset
REQ-025 iRst SHALL immediately, without waiting for a clock edge, force IDLE and zero the counter and latches.
REQ-026 During and after iRst, oReady=1 and all other outputs are 0.
REQ-027 iRst asserted during ACCESS SHALL drop oMemReq at once and produce no done or error pulse.

Verification
REQ-028 LB at addr 0x1003, rdata 0x80FF_1234 -> oMemAddr 0x1000, oMemBe 4'b1111; one cycle after ack, oLoadData 0xFFFF_FF80, oWbValid pulse.
REQ-029 LHU at 0x2002, rdata 0x8001_0000 -> oLoadData 0x0000_8001; same case as LH -> 0xFFFF_8001.
REQ-030 SB at 0x3001, wd 0x0000_00AB -> oMemWe=1, oMemBe 4'b0010, oMemWData 0xABAB_ABAB, oStoreDone one cycle after ack.
REQ-031 LW at 0x4002 -> oMisaligned pulse, oMemReq never high; iLoadTypes=3'b001 with iStoreTypes=3'b001 -> oIllegal pulse.
REQ-032 Ack withheld -> oMemReq held MAX_WAIT cycles, then oBusErr pulse and oReady=1; ack in cycle MAX_WAIT -> normal completion.
REQ-033 iRst pulse mid-ACCESS -> oMemReq=0 same cycle, no oWbValid/oBusErr, and the next request completes normally.
